// File: rtl/regfile_param.sv
// Purpose : parameterised register file with two read ports, one write port and a sequential clear sweep.
// Latency : reads are combinational (0 cycles), and a write accepted this cycle is bypassed to the read ports; writes commit at the next rising edge.
// Backpress: ctrl_writeReady drops for the DEPTH cycles of a clear sweep; writes presented then are dropped, not queued.
//
// Ports
//   clock, ctrl_reset_n            rising-edge clock, asynchronous active-low reset
//   ctrl_writeEnable/Reg, data_writeReg   write request, address and data
//   ctrl_readRegA/B -> data_readRegA/B    two independent combinational read ports
//   ctrl_clear                     start a clear sweep (ignored while one is running)
//   ctrl_writeReady, ctrl_busy     IDLE / SWEEP indication
//   ctrl_clearDone                 one-cycle pulse after the final sweep edge
//
// Optional feature: define REGFILE_ZERO_REG_EN to hard-wire register 0 to zero.

module regfile_param #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    input  logic             ctrl_writeEnable,
    input  logic [AW-1:0]    ctrl_writeReg,
    input  logic [WIDTH-1:0] data_writeReg,
    input  logic [AW-1:0]    ctrl_readRegA,
    input  logic [AW-1:0]    ctrl_readRegB,
    input  logic             ctrl_clear,
    output logic [WIDTH-1:0] data_readRegA,
    output logic [WIDTH-1:0] data_readRegB,
    output logic             ctrl_writeReady,
    output logic             ctrl_busy,
    output logic             ctrl_clearDone
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    sweepCnt;
    logic [WIDTH-1:0] regs [DEPTH];

    logic writeAccept;
    logic sweepLast;

    // An address is usable when it names a real register; with the zero
    // register enabled, address 0 is treated as not backed by storage so it
    // can neither be written nor bypassed.
    function automatic logic addrUsable(input logic [AW-1:0] addr);
        logic inRange;
        inRange = (int'(addr) < DEPTH);
        return inRange && !(ZERO_REG && (addr == '0));
    endfunction

    // Writes are only taken in IDLE; during a sweep they are silently dropped.
    assign writeAccept = ctrl_writeEnable && (state == IDLE) && addrUsable(ctrl_writeReg);

    assign sweepLast = (sweepCnt == AW'(DEPTH - 1));

    assign ctrl_busy       = (state == SWEEP);
    assign ctrl_writeReady = (state == IDLE);

    // Read port A: out-of-range (and the zero register) read 0; a write being
    // accepted to the same address this cycle is forwarded.
    always_comb begin
        data_readRegA = '0;
        if (addrUsable(ctrl_readRegA)) begin
            if (writeAccept && (ctrl_readRegA == ctrl_writeReg)) begin
                data_readRegA = data_writeReg;
            end else begin
                data_readRegA = regs[ctrl_readRegA];
            end
        end
    end

    // Read port B: identical structure, fully independent of port A.
    always_comb begin
        data_readRegB = '0;
        if (addrUsable(ctrl_readRegB)) begin
            if (writeAccept && (ctrl_readRegB == ctrl_writeReg)) begin
                data_readRegB = data_writeReg;
            end else begin
                data_readRegB = regs[ctrl_readRegB];
            end
        end
    end

    // Storage, sweep FSM and done pulse. The sweep clears one register per
    // edge starting at 0; the edge that clears DEPTH-1 returns to IDLE and
    // raises ctrl_clearDone for the following cycle only.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            state          <= IDLE;
            sweepCnt       <= '0;
            ctrl_clearDone <= 1'b0;
        end else begin
            ctrl_clearDone <= 1'b0;
            case (state)
                IDLE: begin
                    // A write and a clear in the same cycle both take effect:
                    // the write lands now and the sweep erases it later.
                    if (writeAccept) begin
                        regs[ctrl_writeReg] <= data_writeReg;
                    end
                    if (ctrl_clear) begin
                        state    <= SWEEP;
                        sweepCnt <= '0;
                    end
                end
                SWEEP: begin
                    regs[sweepCnt] <= '0;
                    if (sweepLast) begin
                        state          <= IDLE;
                        sweepCnt       <= '0;
                        ctrl_clearDone <= 1'b1;
                    end else begin
                        sweepCnt <= sweepCnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    sweepCnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed vector table, multi-cycle sweep and reset
// sequences, randomized traffic against a behavioural model, and a second
// instance with WIDTH=16, DEPTH=20 for out-of-range addressing.

module tb_regfile_param;

    localparam int W = 32;
    localparam int D = 32;
    localparam int A = 5;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          ctrl_reset_n;
    logic          ctrl_writeEnable;
    logic [A-1:0]  ctrl_writeReg;
    logic [W-1:0]  data_writeReg;
    logic [A-1:0]  ctrl_readRegA;
    logic [A-1:0]  ctrl_readRegB;
    logic          ctrl_clear;
    logic [W-1:0]  data_readRegA;
    logic [W-1:0]  data_readRegB;
    logic          ctrl_writeReady;
    logic          ctrl_busy;
    logic          ctrl_clearDone;

    // Small instance signals
    logic          sWe;
    logic [4:0]    sWa;
    logic [15:0]   sWd;
    logic [4:0]    sRa;
    logic [4:0]    sRb;
    logic          sClr;
    logic [15:0]   sA;
    logic [15:0]   sB;
    logic          sRdy;
    logic          sBusy;
    logic          sDone;

    always #5 clock = ~clock;

    regfile_param #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .ctrl_clear       (ctrl_clear),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ctrl_writeReady  (ctrl_writeReady),
        .ctrl_busy        (ctrl_busy),
        .ctrl_clearDone   (ctrl_clearDone)
    );

    regfile_param #(.WIDTH(16), .DEPTH(20), .AW(5)) dutSmall (
        .clock            (clock),
        .ctrl_reset_n     (ctrl_reset_n),
        .ctrl_writeEnable (sWe),
        .ctrl_writeReg    (sWa),
        .data_writeReg    (sWd),
        .ctrl_readRegA    (sRa),
        .ctrl_readRegB    (sRb),
        .ctrl_clear       (sClr),
        .data_readRegA    (sA),
        .data_readRegB    (sB),
        .ctrl_writeReady  (sRdy),
        .ctrl_busy        (sBusy),
        .ctrl_clearDone   (sDone)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mdl [D];
    int          sweepLeft;   // sweep edges still to come; 0 means idle
    logic        expDone;

    function automatic logic writable(input logic [4:0] a);
        return !(ZR && a == 5'd0);
    endfunction

    function automatic logic [31:0] mRead(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd,
                                          input logic idle);
        if (ZR && a == 5'd0) return 32'h0;
        if (idle && we && writable(wa) && a == wa) return wd;
        return mdl[a];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < D; i++) mdl[i] = 32'h0;
        sweepLeft = 0;
        expDone   = 1'b0;
    endtask

    // One clock cycle: drive at negedge, check before the rising edge, then
    // advance the model by that edge's effect.
    task automatic cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra, input logic [4:0] rb, input logic clr,
                         input string tag);
        logic idle;
        @(negedge clock);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wa;
        data_writeReg    = wd;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
        ctrl_clear       = clr;
        #1;
        idle = (sweepLeft == 0);
        check({tag, ".A"},    data_readRegA,   mRead(ra, we, wa, wd, idle));
        check({tag, ".B"},    data_readRegB,   mRead(rb, we, wa, wd, idle));
        check({tag, ".busy"}, ctrl_busy,       !idle);
        check({tag, ".rdy"},  ctrl_writeReady, idle);
        check({tag, ".done"}, ctrl_clearDone,  expDone);
        expDone = 1'b0;
        if (idle) begin
            if (we && writable(wa)) mdl[wa] = wd;
            if (clr) sweepLeft = D;
        end else begin
            mdl[D - sweepLeft] = 32'h0;
            sweepLeft--;
            if (sweepLeft == 0) expDone = 1'b1;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] expA;
        logic [31:0] expB;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r0exp;
        r0exp = ZR ? 32'h0 : 32'hFFFF_FFFF;

        vecs[0] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd6,  32'h0,         32'h0};
        vecs[1] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0,  5'd1,  32'h0,         32'h0};
        vecs[2] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd6,  32'hDEAD_BEEF, 32'h0};
        vecs[3] = '{1'b1, 5'd9,  32'h1234_5678, 5'd9,  5'd9,  32'h1234_5678, 32'h1234_5678};
        vecs[4] = '{1'b0, 5'd0,  32'h0,         5'd9,  5'd5,  32'h1234_5678, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  r0exp,         r0exp};
        vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd0,  5'd9,  r0exp,         32'h1234_5678};
        vecs[7] = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd31, 5'd30, 32'hA5A5_A5A5, 32'h0};
        vecs[8] = '{1'b1, 5'd5,  32'h1111_1111, 5'd5,  5'd5,  32'h1111_1111, 32'h1111_1111};
        vecs[9] = '{1'b0, 5'd0,  32'h0,         5'd5,  5'd31, 32'h1111_1111, 32'hA5A5_A5A5};

        ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
        ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd6; ctrl_clear = 1'b0;
        sWe = 1'b0; sWa = '0; sWd = '0; sRa = '0; sRb = '0; sClr = 1'b0;

        // Reset state
        ctrl_reset_n = 1'b1;
        #1 ctrl_reset_n = 1'b0;
        #1;
        check("rst.A",    data_readRegA,   32'h0);
        check("rst.B",    data_readRegB,   32'h0);
        check("rst.busy", ctrl_busy,       1'b0);
        check("rst.rdy",  ctrl_writeReady, 1'b1);
        check("rst.done", ctrl_clearDone,  1'b0);
        @(negedge clock);
        #2 ctrl_reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            ctrl_writeEnable = vecs[i].we;
            ctrl_writeReg    = vecs[i].wa;
            data_writeReg    = vecs[i].wd;
            ctrl_readRegA    = vecs[i].ra;
            ctrl_readRegB    = vecs[i].rb;
            ctrl_clear       = 1'b0;
            #1;
            check($sformatf("vec%0d.A", i),   data_readRegA,   vecs[i].expA);
            check($sformatf("vec%0d.B", i),   data_readRegB,   vecs[i].expB);
            check($sformatf("vec%0d.rdy", i), ctrl_writeReady, 1'b1);
        end

        // Fresh start for model-checked sections
        @(negedge clock);
        ctrl_writeEnable = 1'b0;
        #2 ctrl_reset_n = 1'b0;
        modelReset();
        @(negedge clock);
        #2 ctrl_reset_n = 1'b1;

        // Fill every register, then clear with a simultaneous write to reg 3
        for (int i = 0; i < D; i++)
            cycle(1'b1, 5'(i), 32'h0101_0101 * (i + 1) ^ 32'h8000_0000, 5'(i), 5'(i + 1), 1'b0, "fill");
        for (int i = 0; i < D; i += 2)
            cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1), 1'b0, "fillrd");
        cycle(1'b1, 5'd3, 32'hCAFE_F00D, 5'd3, 5'd4, 1'b1, "clrstart");
        // Sweep: write attempt in cycle 3 is dropped, re-clear in cycle 5 is ignored
        for (int k = 0; k < D; k++)
            cycle(k == 3, 5'd31, 32'h7777_7777, 5'(k), (k == 3) ? 5'd31 : 5'(k - 1),
                  k == 5, $sformatf("sweep%0d", k));
        // Cycle after the final sweep edge carries the done pulse
        cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd31, 1'b0, "after");
        for (int i = 0; i < D; i += 2)
            cycle(1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1), 1'b0, "cleared");

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic [4:0] wa;
            wa = 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), wa, $urandom,
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), $urandom_range(0, 39) == 0, "rnd");
        end
        while (sweepLeft != 0 || expDone)
            cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 1'b0, "drain");

        // Reset in the middle of a sweep
        for (int i = 20; i < 24; i++)
            cycle(1'b1, 5'(i), 32'h5A00_0000 + i, 5'd0, 5'd0, 1'b0, "prefill");
        cycle(1'b0, 5'd0, 32'h0, 5'd20, 5'd21, 1'b1, "midclr");
        for (int k = 0; k < 10; k++)
            cycle(1'b0, 5'd0, 32'h0, 5'd20, 5'd21, 1'b0, "midsweep");
        @(negedge clock);
        ctrl_readRegA = 5'd20; ctrl_readRegB = 5'd21; ctrl_clear = 1'b0;
        #2 ctrl_reset_n = 1'b0;
        #1;
        check("abort.A",    data_readRegA,   32'h0);
        check("abort.B",    data_readRegB,   32'h0);
        check("abort.busy", ctrl_busy,       1'b0);
        check("abort.rdy",  ctrl_writeReady, 1'b1);
        check("abort.done", ctrl_clearDone,  1'b0);
        modelReset();
        @(negedge clock);
        #2 ctrl_reset_n = 1'b1;
        for (int k = 0; k < 40; k++)
            cycle(1'b0, 5'd0, 32'h0, 5'(k % 32), 5'((k + 7) % 32), 1'b0, "postabort");

        // Small instance: WIDTH=16, DEPTH=20
        @(negedge clock);
        sWe = 1'b1; sWa = 5'd25; sWd = 16'hBEEF; sRa = 5'd25; sRb = 5'd19;
        #1;
        check("s.oor.A",   sA,   16'h0);
        check("s.oor.B",   sB,   16'h0);
        check("s.oor.rdy", sRdy, 1'b1);
        @(negedge clock);
        sWe = 1'b1; sWa = 5'd19; sWd = 16'h1234; sRa = 5'd19; sRb = 5'd25;
        #1;
        check("s.top.A", sA, 16'h1234);
        check("s.top.B", sB, 16'h0);
        for (int i = 0; i < 32; i++) begin
            logic [15:0] eA, eB;
            @(negedge clock);
            sWe = 1'b0; sRa = 5'(i); sRb = 5'(31 - i);
            #1;
            eA = (i == 19) ? 16'h1234 : 16'h0;
            eB = ((31 - i) == 19) ? 16'h1234 : 16'h0;
            check($sformatf("s.rd%0d.A", i), sA, eA);
            check($sformatf("s.rd%0d.B", i), sB, eB);
        end
        check("s.busy", sBusy, 1'b0);
        check("s.done", sDone, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
